// File: rtl/uart_tx_framed.sv
// rtl/uart_tx_framed.sv - framed UART transmitter with baud divider and valid/ready input
// Optional parity bit: define UART_TX_FRAMED_PARITY_EN.
module uart_tx_framed #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic              STOP_LAST = (STOP_BITS == 2);

`ifdef UART_TX_FRAMED_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t               state_q;
   logic [BAUD_W-1:0]    baud_q;
   logic [BIT_W-1:0]     bit_q;
   logic                 stop_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 tx_q;
   logic                 busy_q;
   logic                 baud_end;
   logic                 frame_end;
   logic                 accept;

`ifdef UART_TX_FRAMED_PARITY_EN
   // Parity is taken from the word at accept time, before the shifter consumes it.
   logic par_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         par_q <= 1'b0;
      else if (accept)
         par_q <= (^tx_data) ^ (PARITY_ODD != 0);
   end
`else
   logic unused_parity_odd;
   assign unused_parity_odd = (PARITY_ODD != 0);
`endif

   assign baud_end  = (baud_q == BAUD_LAST);
   assign frame_end = (state_q == S_STOP) && baud_end && (stop_q == STOP_LAST);
   assign tx_ready  = !reset && ((state_q == S_IDLE) || frame_end);
   assign accept    = tx_valid && tx_ready;
   assign tx        = tx_q;
   assign busy      = busy_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else if (accept) begin
         state_q <= S_START;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= tx_data;
         tx_q    <= 1'b0;
         busy_q  <= 1'b1;
      end else if (state_q != S_IDLE) begin
         baud_q <= baud_end ? '0 : baud_q + BAUD_W'(1);
         if (baud_end) begin
            case (state_q)
               S_START: begin
                  state_q <= S_DATA;
                  tx_q    <= shift_q[0];
               end
               S_DATA: begin
                  if (bit_q == BIT_LAST) begin
`ifdef UART_TX_FRAMED_PARITY_EN
                     state_q <= S_PARITY;
                     tx_q    <= par_q;
`else
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
`endif
                  end else begin
                     bit_q   <= bit_q + BIT_W'(1);
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                  end
               end
`ifdef UART_TX_FRAMED_PARITY_EN
               S_PARITY: begin
                  state_q <= S_STOP;
                  tx_q    <= 1'b1;
               end
`endif
               S_STOP: begin
                  if (stop_q == STOP_LAST) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     stop_q <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_framed.sv
// tb/tb_uart_tx_framed.sv - scoreboard bench for uart_tx_framed over two parameter sets
`timescale 1ns/1ps
module tb_uart_tx_framed;
   localparam int DB0 = 8, CPB0 = 4, SB0 = 1, PO0 = 0;
   localparam int DB1 = 5, CPB1 = 1, SB1 = 2, PO1 = 1;
`ifdef UART_TX_FRAMED_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   typedef struct packed {
      logic [8:0]  word;
      logic [31:0] acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] valid = 2'b00;
   logic [8:0] data_a [2];
   logic       tx0, tx1, busy0, busy1, rdy0, rdy1;
   wire  [1:0] tx_w   = {tx1, tx0};
   wire  [1:0] busy_w = {busy1, busy0};
   wire  [1:0] rdy_w  = {rdy1, rdy0};

   exp_t q0[$];
   exp_t q1[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   hs_cnt [2];
   int   last_start [2];
   int   prev_start [2];

   uart_tx_framed #(.DATA_BITS(DB0), .CLKS_PER_BIT(CPB0), .STOP_BITS(SB0), .PARITY_ODD(PO0)) dut0 (
      .clk(clk), .reset(reset), .tx_valid(valid[0]), .tx_data(data_a[0][7:0]),
      .tx_ready(rdy0), .tx(tx0), .busy(busy0));

   uart_tx_framed #(.DATA_BITS(DB1), .CLKS_PER_BIT(CPB1), .STOP_BITS(SB1), .PARITY_ODD(PO1)) dut1 (
      .clk(clk), .reset(reset), .tx_valid(valid[1]), .tx_data(data_a[1][4:0]),
      .tx_ready(rdy1), .tx(tx1), .busy(busy1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      for (int d = 0; d < 2; d++)
         if (!reset && valid[d] && rdy_w[d]) hs_cnt[d]++;

   function automatic int db_of(input int d);  return (d == 0) ? DB0 : DB1;  endfunction
   function automatic int cpb_of(input int d); return (d == 0) ? CPB0 : CPB1; endfunction
   function automatic int sb_of(input int d);  return (d == 0) ? SB0 : SB1;  endfunction
   function automatic int po_of(input int d);  return (d == 0) ? PO0 : PO1;  endfunction
   function automatic int frame_len(input int d);
      return (1 + db_of(d) + P + sb_of(d)) * cpb_of(d);
   endfunction
   function automatic logic [8:0] mask_of(input int d);
      return 9'((1 << db_of(d)) - 1);
   endfunction

   // Serial bit number idx of the frame carrying word w: start, data LSB first, parity, stops.
   function automatic logic frame_bit(input int d, input logic [8:0] w, input int idx);
      int db;
      db = db_of(d);
      if (idx == 0) return 1'b0;
      if (idx <= db) return w[idx-1];
      if (P == 1 && idx == db + 1) return (^w) ^ (po_of(d) != 0);
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, req);
   endtask

   task automatic monitor(input int d);
      int   c, f, start, bad_tx, bad_busy, bad_rdy;
      bit   aborted;
      exp_t e;
      c = cpb_of(d);
      f = frame_len(d);
      forever begin
         @(negedge clk);
         if (reset || tx_w[d] !== 1'b0) continue;
         start = cyc;
         prev_start[d] = last_start[d];
         last_start[d] = start;
         e.word = '0;
         e.acc  = start;
         if (d == 0 && q0.size() > 0) e = q0.pop_front();
         else if (d == 1 && q1.size() > 0) e = q1.pop_front();
         else check($sformatf("d%0d unexpected_start", d), 1, 0);
         bad_tx = 0; bad_busy = 0; bad_rdy = 0; aborted = 0;
         for (int k = 0; k < f; k++) begin
            if (k > 0) @(negedge clk);
            if (reset) begin
               aborted = 1;
               break;
            end
            if (tx_w[d] !== frame_bit(d, e.word, k / c)) bad_tx++;
            if (busy_w[d] !== 1'b1) bad_busy++;
            if (rdy_w[d] !== (k == f - 1)) bad_rdy++;
         end
         if (!aborted) begin
            check($sformatf("d%0d w%0h start_latency", d, e.word), start, e.acc);
            check($sformatf("d%0d w%0h frame_tx_errors", d, e.word), bad_tx, 0);
            check($sformatf("d%0d w%0h frame_busy_errors", d, e.word), bad_busy, 0);
            check($sformatf("d%0d w%0h frame_ready_errors", d, e.word), bad_rdy, 0);
         end
      end
   endtask

   task automatic send(input int d, input logic [8:0] w, input bit hold);
      exp_t e;
      bit   done;
      done = 0;
      valid[d]  = 1'b1;
      data_a[d] = w;
      for (int t = 0; t < 1000 && !done; t++) begin
         @(negedge clk);
         if (rdy_w[d] === 1'b1) begin
            e.word = w & mask_of(d);
            e.acc  = cyc + 1;
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
            done = 1;
            @(posedge clk);
            #1;
            if (!hold) valid[d] = 1'b0;
         end
      end
      if (!done) begin
         check($sformatf("d%0d send_timeout", d), 0, 1);
         valid[d] = 1'b0;
      end
   endtask

   task automatic wait_idle(input int d);
      bit ok;
      ok = 0;
      for (int t = 0; t < 2000 && !ok; t++) begin
         @(negedge clk);
         if (busy_w[d] === 1'b0) ok = 1;
      end
      if (!ok) check($sformatf("d%0d idle_timeout", d), 0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base, w;
      bit hold;
      data_a[0] = '0;
      data_a[1] = '0;
      fork
         monitor(0);
         monitor(1);
      join_none
      repeat (3) @(posedge clk);
      #1;
      check("reset tx0", tx0, 1);
      check("reset busy0", busy0, 0);
      check("reset ready0", rdy0, 0);
      check("reset ready1", rdy1, 0);
      reset = 1'b0;
      #1;
      check("post-reset ready0", rdy0, 1);
      check("post-reset ready1", rdy1, 1);
      check("post-reset tx1", tx1, 1);
      @(posedge clk);
      #1;

      send(0, 9'h0A5, 0);
      wait_idle(0);

      base = hs_cnt[0];
      send(0, 9'h000, 1);
      send(0, 9'h0FF, 0);
      wait_idle(0);
      check("b2b accept count", hs_cnt[0] - base, 2);
      check("b2b frame period", last_start[0] - prev_start[0], frame_len(0));

      send(0, 9'h03C, 0);
      repeat (7) @(posedge clk);
      #1;
      data_a[0] = 9'h0FF;
      wait_idle(0);

      send(0, 9'h055, 0);
      repeat (17) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("mid-frame reset tx0", tx0, 1);
      check("mid-frame reset busy0", busy0, 0);
      check("mid-frame reset ready0", rdy0, 0);
      @(posedge clk);
      #1;
      check("held reset tx0", tx0, 1);
      check("held reset busy0", busy0, 0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("release ready0", rdy0, 1);
      @(posedge clk);
      #1;
      send(0, 9'h0C3, 0);
      wait_idle(0);

      send(1, 9'h013, 0);
      wait_idle(1);

      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 20; i++) begin
            w = $urandom_range(0, 511);
            hold = (i != 19) && ($urandom_range(0, 2) == 0);
            send(d, 9'(w), hold);
            if (!hold) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
            end
         end
         wait_idle(d);
      end

      check("scoreboard0 drained", q0.size(), 0);
      check("scoreboard1 drained", q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
